conv_window_sched: RTL and testbench

- Sequencer that drives one `convolve` datapath instance across a full IMG_W x IMG_H image.
- Operates in valid-only ("VALID") mode with stride 1.
- Fetches each KxK window from a single-port image RAM (1-cycle read latency), presents it on `window`, and pulses `en_convolve`.
- Tracks the 2-cycle datapath latency and writes each `feature_map` result into a feature RAM at the matching output address.
- Sits between the image/feature buffers and the convolve engine; the kernel is loaded elsewhere.

---
 rtl/conv_window_sched_if.sv | 40 ++++
 rtl/conv_window_sched.sv | 160 ++++++++++++++++
 tb/tb_conv_window_sched.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_window_sched_if.sv
// conv_window_sched_if: image RAM read port, convolve datapath strobes
// and feature RAM write port seen by the window scheduler.
interface conv_window_sched_if #(
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int K          = 3,
    parameter int DATA_WIDTH = 8
);
    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;
    localparam int AW    = $clog2(IMG_W * IMG_H);
    localparam int OW0   = $clog2(OUT_W * OUT_H);
    localparam int OW    = (OW0 < 1) ? 1 : OW0;

    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  rd_en;
    logic [AW-1:0]         rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] window [0:K*K-1];
    logic                  en_convolve;
    logic [DATA_WIDTH-1:0] feature_map;
    logic                  feature_out;
    logic                  wr_en;
    logic [OW-1:0]         wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        input  start, rd_data, feature_map, feature_out,
        output busy, done, rd_en, rd_addr, window,
        output en_convolve, wr_en, wr_addr, wr_data
    );

    modport slave (
        output start, rd_data, feature_map, feature_out,
        input  busy, done, rd_en, rd_addr, window,
        input  en_convolve, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/conv_window_sched.sv
// conv_window_sched: walks every valid KxK window of an image, fires the
// convolve datapath and writes each result to the feature RAM.
module conv_window_sched #(
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int K          = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    conv_window_sched_if.master bus
);
    localparam int KK    = K * K;
    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;
    localparam int AW    = $clog2(IMG_W * IMG_H);
    localparam int OW0   = $clog2(OUT_W * OUT_H);
    localparam int OW    = (OW0 < 1) ? 1 : OW0;
    localparam int KW0   = $clog2(KK);
    localparam int KW    = (KW0 < 1) ? 1 : KW0;
    localparam int CW    = $clog2(IMG_W + IMG_H) + 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPT,
        FIRE,
        DRAIN
    } state_t;

    state_t        state;
    logic [KW-1:0] k;
    logic [CW-1:0] kx, ky;
    logic [CW-1:0] ox, oy;
    logic [OW-1:0] pend_addr;

    logic [CW-1:0] kx_n, ky_n;
    logic [CW-1:0] ox_n, oy_n;
    logic          last_k;
    logic          last_pos;

    function automatic logic [AW-1:0] pix(
        input logic [CW-1:0] y,
        input logic [CW-1:0] x
    );
        return AW'(32'(y) * 32'(IMG_W) + 32'(x));
    endfunction

    always_comb begin
        last_k   = (k == KW'(KK - 1));
        last_pos = (ox == CW'(OUT_W - 1)) &&
                   (oy == CW'(OUT_H - 1));
        kx_n = kx + CW'(1);
        ky_n = ky;
        if (kx == CW'(K - 1)) begin
            kx_n = '0;
            ky_n = ky + CW'(1);
        end
        ox_n = ox + CW'(1);
        oy_n = oy;
        if (ox == CW'(OUT_W - 1)) begin
            ox_n = '0;
            oy_n = oy + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            k               <= '0;
            kx              <= '0;
            ky              <= '0;
            ox              <= '0;
            oy              <= '0;
            pend_addr       <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.rd_en       <= 1'b0;
            bus.rd_addr     <= '0;
            bus.en_convolve <= 1'b0;
            for (int i = 0; i < KK; i++)
                bus.window[i] <= '0;
        end else begin
            bus.done        <= 1'b0;
            bus.en_convolve <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state       <= FETCH;
                        bus.busy    <= 1'b1;
                        bus.rd_en   <= 1'b1;
                        bus.rd_addr <= '0;
                        k           <= '0;
                        kx          <= '0;
                        ky          <= '0;
                        ox          <= '0;
                        oy          <= '0;
                    end
                end
                FETCH: begin
                    // data for the read issued last cycle lands now
                    if (k != '0)
                        bus.window[k - KW'(1)] <= bus.rd_data;
                    if (last_k) begin
                        bus.rd_en   <= 1'b0;
                        bus.rd_addr <= '0;
                        state       <= CAPT;
                    end else begin
                        k           <= k + KW'(1);
                        kx          <= kx_n;
                        ky          <= ky_n;
                        bus.rd_addr <= pix(oy + ky_n, ox + kx_n);
                    end
                end
                CAPT: begin
                    bus.window[KK-1] <= bus.rd_data;
                    bus.en_convolve  <= 1'b1;
                    state            <= FIRE;
                end
                FIRE: begin
                    pend_addr <= OW'(32'(oy) * 32'(OUT_W) + 32'(ox));
                    if (last_pos) begin
                        ox    <= '0;
                        oy    <= '0;
                        state <= DRAIN;
                    end else begin
                        ox          <= ox_n;
                        oy          <= oy_n;
                        k           <= '0;
                        kx          <= '0;
                        ky          <= '0;
                        bus.rd_en   <= 1'b1;
                        bus.rd_addr <= pix(oy_n, ox_n);
                        state       <= FETCH;
                    end
                end
                DRAIN: begin
                    if (bus.feature_out) begin
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // one result in flight at most, so pend_addr always names it
    always_comb begin
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = {DATA_WIDTH{1'b0}};
        if (state != IDLE && bus.feature_out) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = pend_addr;
            bus.wr_data = bus.feature_map;
        end
    end
endmodule

// File: tb/tb_conv_window_sched.sv
// tb_conv_window_sched: three scheduler instances (8x8, 3x3, 5x4) with
// RAM and datapath stubs, checked against an arithmetic window model.
module tb_conv_window_sched;
    logic   clk;
    logic   rst;
    logic   start [3];
    logic   spur [3];
    longint cyc;
    int     checks;
    int     errors;

    logic [7:0] img [3][64];
    longint rd_q [3][$];
    longint en_q [3][$];
    longint wr_q [3][$];
    longint dn_q [3][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar i = 0; i < 3; i++) begin : g
        localparam int W = (i == 0) ? 8 : (i == 1) ? 3 : 5;
        localparam int H = (i == 0) ? 8 : (i == 1) ? 3 : 4;

        conv_window_sched_if #(
            .IMG_W(W), .IMG_H(H), .K(3), .DATA_WIDTH(8)
        ) ifc ();

        conv_window_sched #(
            .IMG_W(W), .IMG_H(H), .K(3), .DATA_WIDTH(8)
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(ifc.master)
        );

        logic [7:0] s1 = 8'd0;
        logic [7:0] s2 = 8'd0;
        logic       v1 = 1'b0;
        logic       v2 = 1'b0;

        always @(posedge clk) begin
            int s;
            s = 0;
            for (int j = 0; j < 9; j++)
                s += int'(ifc.window[j]);
            v1 <= ifc.en_convolve;
            s1 <= 8'(s);
            v2 <= v1;
            s2 <= s1;
            if (ifc.rd_en)
                ifc.rd_data <= img[i][int'(ifc.rd_addr)];
        end

        assign ifc.feature_out = v2 | spur[i];
        assign ifc.feature_map = s2;
        assign ifc.start       = start[i];

        always @(negedge clk) begin
            int s;
            if (rst) begin
                if (ifc.rd_en)
                    rd_q[i].push_back(cyc * 65536 +
                                      longint'(ifc.rd_addr));
                if (ifc.en_convolve) begin
                    s = 0;
                    for (int j = 0; j < 9; j++)
                        s += int'(ifc.window[j]);
                    en_q[i].push_back(cyc * 65536 + (s & 255));
                end
                if (ifc.wr_en)
                    wr_q[i].push_back(cyc * 65536 +
                                      longint'(ifc.wr_addr) * 256 +
                                      longint'(ifc.wr_data));
                if (ifc.done)
                    dn_q[i].push_back(cyc);
            end
        end
    end

    task automatic chk(input string tag, input longint got,
                       input longint ex);
        checks++;
        assert (got === ex) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, ex);
        end
    endtask

    function automatic longint pop(input int id, input int which);
        longint v;
        v = -1;
        case (which)
            0: if (rd_q[id].size() != 0) v = rd_q[id].pop_front();
            1: if (en_q[id].size() != 0) v = en_q[id].pop_front();
            2: if (wr_q[id].size() != 0) v = wr_q[id].pop_front();
            default: if (dn_q[id].size() != 0) v = dn_q[id].pop_front();
        endcase
        return v;
    endfunction

    // every valid window in raster order, 11 cycles apart
    task automatic check_run(input int id, input int w, input int h,
                             input longint t0);
        int ow, np, oy, ox, a, sum;
        string tg;
        ow = w - 2;
        np = ow * (h - 2);
        for (int p = 0; p < np; p++) begin
            oy  = p / ow;
            ox  = p % ow;
            sum = 0;
            for (int kk = 0; kk < 9; kk++) begin
                a   = (oy + kk / 3) * w + ox + kk % 3;
                sum += int'(img[id][a]);
                tg  = $sformatf("rd i%0d p%0d k%0d", id, p, kk);
                chk(tg, pop(id, 0),
                    (t0 + 1 + 11 * p + kk) * 65536 + a);
            end
            tg = $sformatf("en i%0d p%0d", id, p);
            chk(tg, pop(id, 1),
                (t0 + 11 + 11 * p) * 65536 + (sum & 255));
            tg = $sformatf("wr i%0d p%0d", id, p);
            chk(tg, pop(id, 2),
                (t0 + 13 + 11 * p) * 65536 + p * 256 + (sum & 255));
        end
        chk($sformatf("done i%0d", id), pop(id, 3), t0 + 11 * np + 3);
    endtask

    task automatic check_quiet(input int id, input string tag);
        chk({tag, " reads"},  rd_q[id].size(), 0);
        chk({tag, " fires"},  en_q[id].size(), 0);
        chk({tag, " writes"}, wr_q[id].size(), 0);
        chk({tag, " dones"},  dn_q[id].size(), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, " busy"},    g[0].ifc.busy, 0);
        chk({tag, " done"},    g[0].ifc.done, 0);
        chk({tag, " rd_en"},   g[0].ifc.rd_en, 0);
        chk({tag, " rd_addr"}, g[0].ifc.rd_addr, 0);
        chk({tag, " en"},      g[0].ifc.en_convolve, 0);
        chk({tag, " wr_en"},   g[0].ifc.wr_en, 0);
        chk({tag, " wr_addr"}, g[0].ifc.wr_addr, 0);
        chk({tag, " wr_data"}, g[0].ifc.wr_data, 0);
        chk({tag, " win1"},    g[0].ifc.window[1], 0);
        chk({tag, " win8"},    g[0].ifc.window[8], 0);
    endtask

    initial begin
        longint t0, t0b;
        int     ex;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            spur[i]  = 1'b0;
        end
        for (int a = 0; a < 64; a++) begin
            img[0][a] = 8'(a);
            img[1][a] = 8'($urandom);
            img[2][a] = 8'($urandom);
        end
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // abort: reset dropped in the fifth cycle of the first fetch
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        chk("abort busy",  g[0].ifc.busy, 1);
        chk("abort rd_en", g[0].ifc.rd_en, 1);
        repeat (4) @(negedge clk);
        #1 rst = 1'b0;
        #1 check_outputs_zero("abort");
        for (int i = 0; i < 3; i++) begin
            rd_q[i].delete();
            en_q[i].delete();
            wr_q[i].delete();
            dn_q[i].delete();
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (450) @(negedge clk);
        check_quiet(0, "post-abort");

        // all three geometries together, re-pulsed start on 8x8
        @(negedge clk);
        for (int i = 0; i < 3; i++) start[i] = 1'b1;
        t0 = cyc;
        for (int n = 1; n <= 420; n++) begin
            @(negedge clk);
            start[1] = 1'b0;
            start[2] = 1'b0;
            start[0] = (n == 3 || n == 50);
            if (n == 11) begin
                chk("win en", g[0].ifc.en_convolve, 1);
                for (int kk = 0; kk < 9; kk++) begin
                    ex = (kk / 3) * 8 + kk % 3;
                    chk($sformatf("win00 k%0d", kk),
                        g[0].ifc.window[kk], ex);
                end
            end
        end
        start[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_run(i, (i == 0) ? 8 : (i == 1) ? 3 : 5,
                         (i == 0) ? 8 : (i == 1) ? 3 : 4, t0);
            check_quiet(i, $sformatf("run1 i%0d tail", i));
        end
        chk("idle busy", g[0].ifc.busy, 0);

        // feature_out while idle must not write
        spur[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("spur wr_en", g[0].ifc.wr_en, 0);
        end
        spur[0] = 1'b0;
        check_quiet(0, "spur");

        // back-to-back images on random data
        for (int a = 0; a < 64; a++) img[0][a] = 8'($urandom);
        @(negedge clk);
        start[0] = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start[0] = 1'b0;
        for (int n = 0; n < 450; n++) begin
            if (g[0].ifc.done) break;
            @(negedge clk);
        end
        chk("b2b done1", g[0].ifc.done, 1);
        @(negedge clk);
        start[0] = 1'b1;
        t0b = cyc;
        @(negedge clk);
        start[0] = 1'b0;
        chk("b2b busy2", g[0].ifc.busy, 1);
        for (int n = 0; n < 450; n++) begin
            if (g[0].ifc.done) break;
            @(negedge clk);
        end
        chk("b2b done2", g[0].ifc.done, 1);
        repeat (3) @(negedge clk);
        check_run(0, 8, 8, t0);
        check_run(0, 8, 8, t0b);
        check_quiet(0, "b2b tail");
        chk("b2b idle busy", g[0].ifc.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
